id_issue: RTL and testbench
===========================

# id_issue

Parametrised decode/issue stage for the MIPS core, placed between instruction fetch and EX. Each cycle it decodes one instruction from the logic, shift and move subset. It reads the register file and resolves operands through an N-source forwarding network, with the youngest source taking priority. The result is registered into an ID/EX pipeline register with a valid/ready handshake. Unlike the previous decoder, it detects load-use hazards, stalls, inserts bubbles, honours back-pressure and flush, and counts stall cycles.

## Interface
Parameters:
- DATA_W, 32: datapath width.
- REG_AW, 5: register address width.
- FWD_N, 2: number of forwarding sources. Index 0 is the youngest (EX); higher indices are older (MEM, WB, ...).
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- flush  in  1  kills the held instruction and blocks acceptance this cycle.
- if_valid  in  1  fetch offers an instruction.
- if_ready  out  1  stage accepts the instruction this cycle.
- if_pc  in  32  PC of the offered instruction.
- if_inst  in  32  offered instruction word.
- rf_raddr1, rf_raddr2  out  REG_AW  register file read addresses (rs, rt).
- rf_re1, rf_re2  out  1  read enables.
- rf_rdata1, rf_rdata2  in  DATA_W  register file read data.
- fwd_we  in  FWD_N  forwarding source i will write a register.
- fwd_waddr  in  FWD_N*REG_AW  destination of source i; slice i is [i*REG_AW +: REG_AW].
- fwd_wdata  in  FWD_N*DATA_W  result of source i.
- fwd_pend  in  FWD_N  result of source i is not yet available (load in flight).
- ex_valid  out  1  ID/EX register holds an instruction.
- ex_ready  in  1  EX consumes it this cycle.
- ex_aluop  out  8  operation code from the shared defines header (EXE_*_OP).
- ex_alusel  out  3  result class (EXE_RES_*).
- ex_op1, ex_op2  out  DATA_W  resolved operands.
- ex_wd  out  REG_AW  destination register.
- ex_wreg  out  1  write enable for the destination register.
- ex_pc  out  32  PC of the held instruction.
- ex_invalid  out  1  reserved/unsupported instruction.
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

## Operation
- Decode is combinational and covers:
  - R-type: OR, AND, XOR, NOR, SLLV, SRLV, SRAV, SLL, SRL, SRA, MOVN, MOVZ, MFHI, MFLO, MTHI, MTLO, SYNC.
  - I-type: ORI, ANDI, XORI, LUI, PREF.
- Destination register: rd for R-type, rt for I-type.
- Immediate forms:
  - ORI, ANDI, XORI: zero-extend imm16.
  - LUI: {imm16, 16'h0}, with rs read.
  - SLL, SRL, SRA: op1 = zero-extended sa (if_inst[10:6]); op2 = rt.
- Operand resolution per port p, when the port is read-enabled:
  - Address 0 gives 0, with no forwarding and no hazard.
  - Otherwise the winner is the lowest i with fwd_we[i] and fwd_waddr[i] == address.
  - If the winner has fwd_pend=1, a hazard is raised.
  - If there is a winner without pending, the operand is fwd_wdata[i].
  - If there is no winner, the operand is rf_rdata.
- A port that is not read gives the immediate (op2) or 0.
- MOVN/MOVZ: ex_wreg is computed from the resolved op2 (MOVN: op2 != 0; MOVZ: op2 == 0).
- MTHI/MTLO and SYNC/PREF set ex_wreg=0. SYNC/PREF use the NOP op/sel.
- Undecodable instruction: accepted with ex_invalid=1, ex_wreg=0, NOP op/sel.
- Handshake: `if_ready = !rst && !flush && !hazard && (!ex_valid || ex_ready)`.
- Register update priority:
  - rst: clear the register.
  - flush: ex_valid <= 0.
  - Accept (if_valid && if_ready): load the decoded fields, ex_valid <= 1.
  - Else if ex_ready: ex_valid <= 0 (bubble).
  - Else: hold all ex_* outputs.
- stall_cnt increments on each cycle with if_valid && hazard && !flush. It saturates at all-ones.

## Timing
- Reset values: ex_valid=0; ex_aluop, ex_alusel, ex_op1, ex_op2, ex_wd, ex_wreg, ex_pc, ex_invalid all 0; stall_cnt=0.
- rf_* and if_ready are combinational and follow the inputs in the same cycle.
- Latency: an instruction accepted in cycle T appears on ex_* with ex_valid=1 in cycle T+1.
- Throughput: 1 instruction per cycle with no hazard and ex_ready=1.
- Hazard resolves in the cycle fwd_pend drops; the instruction is accepted in that cycle with the forwarded data.
- Back-pressure (ex_valid && !ex_ready): all ex_* outputs stay bit-stable and if_ready=0.
- rst mid-stall or mid-hold: the next cycle shows reset values and stall_cnt=0.
- flush together with an accept-eligible if_valid: nothing is accepted, and ex_valid=0 the next cycle.

## Test plan
- After rst, issue 0x34011100 (ori $1,$0,0x1100). Required next cycle: ex_valid=1, ex_op1=0, ex_op2=0x00001100, ex_wd=1, ex_wreg=1, alusel=logic.
- Priority: fwd0 writes $1=0x0000AAAA, fwd1 writes $1=0x0000BBBB; issue or $3,$1,$1. Required: ex_op1=ex_op2=0x0000AAAA.
- Zero register: fwd0 writes $0=0xFFFFFFFF; issue or $2,$0,$0. Required: ex_op1=ex_op2=0.
- Load-use: fwd0 writes $4 with pend=1 for 2 cycles, then data 0x12345678; issue and $5,$4,$4. Required: if_ready=0 for 2 cycles, 2 bubbles, stall_cnt=2, then ex_op1=0x12345678.
- Back-pressure and flush: hold ex_ready=0 for 3 cycles. Required: ex_* stable and if_ready=0 throughout. Then assert flush. Required next cycle: ex_valid=0 and the offered instruction is not consumed.
- movn $5,$6,$7 with $7 forwarded as 0 gives ex_wreg=0; with $7=1 gives ex_wreg=1. An undecodable opcode 0xFC000000 gives ex_invalid=1 and ex_wreg=0.

Source files
------------

// File: rtl/id_issue_if.sv
// Bus bundle for the decode/issue stage: fetch side, register file reads,
// forwarding network and the ID/EX register outputs.
interface id_issue_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int FWD_N  = 2,
  parameter int CNT_W  = 16
);
  logic                     flush;
  logic                     if_valid;
  logic                     if_ready;
  logic [31:0]              if_pc;
  logic [31:0]              if_inst;
  logic [REG_AW-1:0]        rf_raddr1, rf_raddr2;
  logic                     rf_re1, rf_re2;
  logic [DATA_W-1:0]        rf_rdata1, rf_rdata2;
  logic [FWD_N-1:0]         fwd_we;
  logic [FWD_N*REG_AW-1:0]  fwd_waddr;
  logic [FWD_N*DATA_W-1:0]  fwd_wdata;
  logic [FWD_N-1:0]         fwd_pend;
  logic                     ex_valid;
  logic                     ex_ready;
  logic [7:0]               ex_aluop;
  logic [2:0]               ex_alusel;
  logic [DATA_W-1:0]        ex_op1, ex_op2;
  logic [REG_AW-1:0]        ex_wd;
  logic                     ex_wreg;
  logic [31:0]              ex_pc;
  logic                     ex_invalid;
  logic [CNT_W-1:0]         stall_cnt;

  // The issue stage itself.
  modport slave (
    input  flush, if_valid, if_pc, if_inst, rf_rdata1, rf_rdata2,
           fwd_we, fwd_waddr, fwd_wdata, fwd_pend, ex_ready,
    output if_ready, rf_raddr1, rf_raddr2, rf_re1, rf_re2,
           ex_valid, ex_aluop, ex_alusel, ex_op1, ex_op2, ex_wd, ex_wreg,
           ex_pc, ex_invalid, stall_cnt
  );

  // The surrounding pipeline (fetch, register file, later stages).
  modport master (
    output flush, if_valid, if_pc, if_inst, rf_rdata1, rf_rdata2,
           fwd_we, fwd_waddr, fwd_wdata, fwd_pend, ex_ready,
    input  if_ready, rf_raddr1, rf_raddr2, rf_re1, rf_re2,
           ex_valid, ex_aluop, ex_alusel, ex_op1, ex_op2, ex_wd, ex_wreg,
           ex_pc, ex_invalid, stall_cnt
  );
endinterface

// File: rtl/id_issue.sv
// Decode/issue stage: decodes logic/shift/move instructions, resolves operands
// through a youngest-first forwarding network, stalls on load-use hazards and
// registers the result into a valid/ready ID/EX register.
module id_issue #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int FWD_N  = 2,
  parameter int CNT_W  = 16
) (
  input logic     clk,
  input logic     rst,
  id_issue_if.slave bus
);
  localparam logic [7:0] OP_NOP  = 8'h00, OP_OR   = 8'h25, OP_AND  = 8'h24,
                         OP_XOR  = 8'h26, OP_NOR  = 8'h27, OP_SLLV = 8'h04,
                         OP_SRLV = 8'h06, OP_SRAV = 8'h07, OP_SLL  = 8'h7c,
                         OP_SRL  = 8'h02, OP_SRA  = 8'h03, OP_MOVZ = 8'h0a,
                         OP_MOVN = 8'h0b, OP_MFHI = 8'h10, OP_MTHI = 8'h11,
                         OP_MFLO = 8'h12, OP_MTLO = 8'h13;
  localparam logic [2:0] RES_NOP = 3'd0, RES_LOGIC = 3'd1, RES_SHIFT = 3'd2,
                         RES_MOVE = 3'd3;

  logic [5:0]  opc, fn;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm16;
  assign opc   = bus.if_inst[31:26];
  assign rs    = bus.if_inst[25:21];
  assign rt    = bus.if_inst[20:16];
  assign rd    = bus.if_inst[15:11];
  assign sa    = bus.if_inst[10:6];
  assign fn    = bus.if_inst[5:0];
  assign imm16 = bus.if_inst[15:0];

  logic [7:0]        d_aluop;
  logic [2:0]        d_alusel;
  logic              d_re1, d_re2, d_wreg, d_inval, d_movn, d_movz, fmt_ok;
  logic [REG_AW-1:0] d_wd;
  logic [DATA_W-1:0] d_imm1, d_imm2;

  // Instruction decode; undecodable words collapse to a non-writing NOP.
  always_comb begin
    d_aluop = OP_NOP; d_alusel = RES_NOP; d_re1 = 1'b0; d_re2 = 1'b0;
    d_wreg = 1'b0; d_inval = 1'b0; d_movn = 1'b0; d_movz = 1'b0;
    d_wd = REG_AW'(rd); d_imm1 = '0; d_imm2 = '0;
    // shift-by-sa forms need rs==0, every other SPECIAL form needs sa==0
    fmt_ok = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? (rs == 5'd0) : (sa == 5'd0);
    case (opc)
      6'h00: begin
        if (!fmt_ok) d_inval = 1'b1;
        else case (fn)
          6'h25: begin d_aluop = OP_OR;   d_alusel = RES_LOGIC; d_re1 = 1'b1; d_re2 = 1'b1; d_wreg = 1'b1; end
          6'h24: begin d_aluop = OP_AND;  d_alusel = RES_LOGIC; d_re1 = 1'b1; d_re2 = 1'b1; d_wreg = 1'b1; end
          6'h26: begin d_aluop = OP_XOR;  d_alusel = RES_LOGIC; d_re1 = 1'b1; d_re2 = 1'b1; d_wreg = 1'b1; end
          6'h27: begin d_aluop = OP_NOR;  d_alusel = RES_LOGIC; d_re1 = 1'b1; d_re2 = 1'b1; d_wreg = 1'b1; end
          6'h04: begin d_aluop = OP_SLLV; d_alusel = RES_SHIFT; d_re1 = 1'b1; d_re2 = 1'b1; d_wreg = 1'b1; end
          6'h06: begin d_aluop = OP_SRLV; d_alusel = RES_SHIFT; d_re1 = 1'b1; d_re2 = 1'b1; d_wreg = 1'b1; end
          6'h07: begin d_aluop = OP_SRAV; d_alusel = RES_SHIFT; d_re1 = 1'b1; d_re2 = 1'b1; d_wreg = 1'b1; end
          6'h00: begin d_aluop = OP_SLL;  d_alusel = RES_SHIFT; d_re2 = 1'b1; d_wreg = 1'b1; d_imm1 = DATA_W'(sa); end
          6'h02: begin d_aluop = OP_SRL;  d_alusel = RES_SHIFT; d_re2 = 1'b1; d_wreg = 1'b1; d_imm1 = DATA_W'(sa); end
          6'h03: begin d_aluop = OP_SRA;  d_alusel = RES_SHIFT; d_re2 = 1'b1; d_wreg = 1'b1; d_imm1 = DATA_W'(sa); end
          6'h0b: begin d_aluop = OP_MOVN; d_alusel = RES_MOVE;  d_re1 = 1'b1; d_re2 = 1'b1; d_movn = 1'b1; end
          6'h0a: begin d_aluop = OP_MOVZ; d_alusel = RES_MOVE;  d_re1 = 1'b1; d_re2 = 1'b1; d_movz = 1'b1; end
          6'h10: begin d_aluop = OP_MFHI; d_alusel = RES_MOVE;  d_wreg = 1'b1; end
          6'h12: begin d_aluop = OP_MFLO; d_alusel = RES_MOVE;  d_wreg = 1'b1; end
          6'h11: begin d_aluop = OP_MTHI; d_re1 = 1'b1; end
          6'h13: begin d_aluop = OP_MTLO; d_re1 = 1'b1; end
          6'h0f: ;  // SYNC: plain NOP
          default: d_inval = 1'b1;
        endcase
      end
      6'h0d: begin d_aluop = OP_OR;  d_alusel = RES_LOGIC; d_re1 = 1'b1; d_wreg = 1'b1; d_wd = REG_AW'(rt); d_imm2 = DATA_W'(imm16); end
      6'h0c: begin d_aluop = OP_AND; d_alusel = RES_LOGIC; d_re1 = 1'b1; d_wreg = 1'b1; d_wd = REG_AW'(rt); d_imm2 = DATA_W'(imm16); end
      6'h0e: begin d_aluop = OP_XOR; d_alusel = RES_LOGIC; d_re1 = 1'b1; d_wreg = 1'b1; d_wd = REG_AW'(rt); d_imm2 = DATA_W'(imm16); end
      6'h0f: begin d_aluop = OP_OR;  d_alusel = RES_LOGIC; d_re1 = 1'b1; d_wreg = 1'b1; d_wd = REG_AW'(rt); d_imm2 = DATA_W'({imm16, 16'h0}); end
      6'h33: d_wd = REG_AW'(rt);  // PREF: plain NOP
      default: d_inval = 1'b1;
    endcase
    if (d_inval) begin
      d_aluop = OP_NOP; d_alusel = RES_NOP; d_re1 = 1'b0; d_re2 = 1'b0; d_wreg = 1'b0;
      d_movn = 1'b0; d_movz = 1'b0; d_wd = '0; d_imm1 = '0; d_imm2 = '0;
    end
  end

  // {pending, data} for one read port; lower index overrides, so scan from the oldest.
  function automatic logic [DATA_W:0] resolve(
    input logic [REG_AW-1:0]       a,
    input logic [DATA_W-1:0]       rdata,
    input logic [FWD_N-1:0]        we,
    input logic [FWD_N*REG_AW-1:0] wa,
    input logic [FWD_N*DATA_W-1:0] wd,
    input logic [FWD_N-1:0]        pend
  );
    logic [DATA_W:0] r;
    r = {1'b0, rdata};
    for (int i = FWD_N - 1; i >= 0; i--)
      if (we[i] && wa[i*REG_AW +: REG_AW] == a) r = {pend[i], wd[i*DATA_W +: DATA_W]};
    if (a == '0) r = '0;
    return r;
  endfunction

  logic [DATA_W:0]   res1, res2;
  logic [DATA_W-1:0] op1, op2;
  logic              wreg, hazard, accept;

  assign bus.rf_raddr1 = REG_AW'(rs);
  assign bus.rf_raddr2 = REG_AW'(rt);
  assign bus.rf_re1    = d_re1;
  assign bus.rf_re2    = d_re2;

  // Operand resolution, hazard detection and conditional-move write enable.
  always_comb begin
    res1   = resolve(REG_AW'(rs), bus.rf_rdata1, bus.fwd_we, bus.fwd_waddr, bus.fwd_wdata, bus.fwd_pend);
    res2   = resolve(REG_AW'(rt), bus.rf_rdata2, bus.fwd_we, bus.fwd_waddr, bus.fwd_wdata, bus.fwd_pend);
    hazard = (d_re1 && res1[DATA_W]) || (d_re2 && res2[DATA_W]);
    op1    = d_re1 ? res1[DATA_W-1:0] : d_imm1;
    op2    = d_re2 ? res2[DATA_W-1:0] : d_imm2;
    wreg   = d_movn ? (op2 != '0) : d_movz ? (op2 == '0) : d_wreg;
  end

  assign bus.if_ready = !rst && !bus.flush && !hazard && (!bus.ex_valid || bus.ex_ready);
  assign accept       = bus.if_valid && bus.if_ready;

  // ID/EX register and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ex_valid <= 1'b0; bus.ex_aluop <= '0; bus.ex_alusel <= '0;
      bus.ex_op1 <= '0; bus.ex_op2 <= '0; bus.ex_wd <= '0; bus.ex_wreg <= 1'b0;
      bus.ex_pc <= '0; bus.ex_invalid <= 1'b0; bus.stall_cnt <= '0;
    end else begin
      if (bus.flush) bus.ex_valid <= 1'b0;
      else if (accept) begin
        bus.ex_valid <= 1'b1; bus.ex_aluop <= d_aluop; bus.ex_alusel <= d_alusel;
        bus.ex_op1 <= op1; bus.ex_op2 <= op2; bus.ex_wd <= d_wd; bus.ex_wreg <= wreg;
        bus.ex_pc <= bus.if_pc; bus.ex_invalid <= d_inval;
      end else if (bus.ex_ready) bus.ex_valid <= 1'b0;
      if (bus.if_valid && hazard && !bus.flush && bus.stall_cnt != '1)
        bus.stall_cnt <= bus.stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_id_issue.sv
// Randomised bench for id_issue against a cycle-level instruction model.
module tb_id_issue;
  localparam int DATA_W = 32, REG_AW = 5, FWD_N = 2, CNT_W = 16;
  localparam logic [7:0] A_NOP = 8'h00, A_OR = 8'h25, A_AND = 8'h24, A_XOR = 8'h26,
                         A_NOR = 8'h27, A_SLLV = 8'h04, A_SRLV = 8'h06, A_SRAV = 8'h07,
                         A_SLL = 8'h7c, A_SRL = 8'h02, A_SRA = 8'h03, A_MOVZ = 8'h0a,
                         A_MOVN = 8'h0b, A_MFHI = 8'h10, A_MTHI = 8'h11, A_MFLO = 8'h12,
                         A_MTLO = 8'h13;
  localparam logic [5:0] FN_TAB [17] = '{6'h25, 6'h24, 6'h26, 6'h27, 6'h04, 6'h06, 6'h07,
                                         6'h00, 6'h02, 6'h03, 6'h0b, 6'h0a, 6'h10, 6'h12,
                                         6'h11, 6'h13, 6'h0f};
  localparam logic [5:0] OPC_TAB [5] = '{6'h0d, 6'h0c, 6'h0e, 6'h0f, 6'h33};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_issue_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_N(FWD_N), .CNT_W(CNT_W)) bus();
  id_issue #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_N(FWD_N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  logic [31:0] rf [32];
  assign bus.rf_rdata1 = rf[bus.rf_raddr1];
  assign bus.rf_rdata2 = rf[bus.rf_raddr2];

  typedef struct packed {
    logic vld; logic [7:0] op; logic [2:0] sel; logic [31:0] op1, op2;
    logic [4:0] wd; logic wreg; logic [31:0] pc; logic inv;
  } ex_t;

  ex_t m;
  int  scnt, total, bad;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Architectural value of a register as seen at decode: {pending, value}.
  function automatic logic [32:0] opnd(input logic [4:0] a);
    if (a == 5'd0) return 33'd0;
    for (int i = 0; i < FWD_N; i++)
      if (bus.fwd_we[i] && bus.fwd_waddr[i*REG_AW +: REG_AW] == a)
        return {bus.fwd_pend[i], bus.fwd_wdata[i*DATA_W +: DATA_W]};
    return {1'b0, rf[a]};
  endfunction

  // What the instruction on the fetch bus should issue as, and whether it must wait.
  task automatic ref_dec(output ex_t e, output logic hz);
    logic [31:0] w;
    logic [5:0]  opc, fn;
    logic [4:0]  rs, rt, rd, sa;
    logic [32:0] a, b;
    logic        ua, ub, mn, mz, shimm, ok;
    logic [31:0] imm;
    w = bus.if_inst;
    opc = w[31:26]; fn = w[5:0]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sa = w[10:6];
    a = opnd(rs); b = opnd(rt);
    e = '0; e.vld = 1'b1; e.pc = bus.if_pc;
    ua = 0; ub = 0; mn = 0; mz = 0; shimm = 0; imm = 32'd0;
    if (opc == 6'h00) begin
      e.wd = rd;
      ok = (fn inside {6'h00, 6'h02, 6'h03}) ? (rs == 0) : (sa == 0);
      if (!ok) e.inv = 1'b1;
      else case (fn)
        6'h25: begin e.op = A_OR;   e.sel = 3'd1; ua = 1; ub = 1; e.wreg = 1; end
        6'h24: begin e.op = A_AND;  e.sel = 3'd1; ua = 1; ub = 1; e.wreg = 1; end
        6'h26: begin e.op = A_XOR;  e.sel = 3'd1; ua = 1; ub = 1; e.wreg = 1; end
        6'h27: begin e.op = A_NOR;  e.sel = 3'd1; ua = 1; ub = 1; e.wreg = 1; end
        6'h04: begin e.op = A_SLLV; e.sel = 3'd2; ua = 1; ub = 1; e.wreg = 1; end
        6'h06: begin e.op = A_SRLV; e.sel = 3'd2; ua = 1; ub = 1; e.wreg = 1; end
        6'h07: begin e.op = A_SRAV; e.sel = 3'd2; ua = 1; ub = 1; e.wreg = 1; end
        6'h00: begin e.op = A_SLL;  e.sel = 3'd2; ub = 1; shimm = 1; e.wreg = 1; end
        6'h02: begin e.op = A_SRL;  e.sel = 3'd2; ub = 1; shimm = 1; e.wreg = 1; end
        6'h03: begin e.op = A_SRA;  e.sel = 3'd2; ub = 1; shimm = 1; e.wreg = 1; end
        6'h0b: begin e.op = A_MOVN; e.sel = 3'd3; ua = 1; ub = 1; mn = 1; end
        6'h0a: begin e.op = A_MOVZ; e.sel = 3'd3; ua = 1; ub = 1; mz = 1; end
        6'h10: begin e.op = A_MFHI; e.sel = 3'd3; e.wreg = 1; end
        6'h12: begin e.op = A_MFLO; e.sel = 3'd3; e.wreg = 1; end
        6'h11: begin e.op = A_MTHI; ua = 1; end
        6'h13: begin e.op = A_MTLO; ua = 1; end
        6'h0f: ;
        default: e.inv = 1'b1;
      endcase
    end else begin
      e.wd = rt;
      case (opc)
        6'h0d: begin e.op = A_OR;  e.sel = 3'd1; ua = 1; e.wreg = 1; imm = {16'h0, w[15:0]}; end
        6'h0c: begin e.op = A_AND; e.sel = 3'd1; ua = 1; e.wreg = 1; imm = {16'h0, w[15:0]}; end
        6'h0e: begin e.op = A_XOR; e.sel = 3'd1; ua = 1; e.wreg = 1; imm = {16'h0, w[15:0]}; end
        6'h0f: begin e.op = A_OR;  e.sel = 3'd1; ua = 1; e.wreg = 1; imm = {w[15:0], 16'h0}; end
        6'h33: ;
        default: e.inv = 1'b1;
      endcase
    end
    e.op1 = ua ? a[31:0] : (shimm ? {27'd0, sa} : 32'd0);
    e.op2 = ub ? b[31:0] : imm;
    if (mn) e.wreg = (e.op2 != 0);
    if (mz) e.wreg = (e.op2 == 0);
    hz = (ua && a[32]) || (ub && b[32]);
    if (e.inv) begin
      e.op = A_NOP; e.sel = 3'd0; e.op1 = 0; e.op2 = 0; e.wd = 0; e.wreg = 0; hz = 0;
    end
  endtask

  task automatic check_out();
    chk("ex_valid", bus.ex_valid, m.vld);
    chk("ex_aluop", bus.ex_aluop, m.op);
    chk("ex_alusel", bus.ex_alusel, m.sel);
    chk("ex_op1", bus.ex_op1, m.op1);
    chk("ex_op2", bus.ex_op2, m.op2);
    chk("ex_wd", bus.ex_wd, m.wd);
    chk("ex_wreg", bus.ex_wreg, m.wreg);
    chk("ex_pc", bus.ex_pc, m.pc);
    chk("ex_invalid", bus.ex_invalid, m.inv);
    chk("stall_cnt", bus.stall_cnt, scnt);
  endtask

  // One cycle: inputs already driven after a negedge.
  task automatic step();
    ex_t  nx;
    logic hz, rdy;
    #1;
    ref_dec(nx, hz);
    rdy = !rst && !bus.flush && !hz && (!m.vld || bus.ex_ready);
    chk("if_ready", bus.if_ready, rdy);
    if (rst) begin m = '0; scnt = 0; end
    else begin
      if (bus.flush) m.vld = 1'b0;
      else if (bus.if_valid && rdy) m = nx;
      else if (bus.ex_ready) m.vld = 1'b0;
      if (bus.if_valid && hz && !bus.flush && scnt < (1 << CNT_W) - 1) scnt++;
    end
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic set_fwd0(input logic [4:0] a, input logic [31:0] d, input logic p);
    bus.fwd_we = 2'b01; bus.fwd_waddr = {5'd0, a}; bus.fwd_wdata = {32'd0, d}; bus.fwd_pend = {1'b0, p};
  endtask

  function automatic logic [31:0] rnd_inst();
    int k;
    logic [4:0] rs, rt, rd, sa;
    logic [5:0] fn;
    k  = $urandom_range(0, 23);
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
    if (k < 17) begin
      fn = FN_TAB[k];
      sa = ($urandom_range(0, 9) == 0 || fn inside {6'h00, 6'h02, 6'h03}) ? 5'($urandom) : 5'd0;
      if (fn inside {6'h00, 6'h02, 6'h03} && $urandom_range(0, 9) != 0) rs = 5'd0;
      return {6'h00, rs, rt, rd, sa, fn};
    end
    if (k < 22) return {OPC_TAB[k-17], rs, rt, 16'($urandom)};
    if (k == 22) return $urandom;
    return {6'h3f, 26'($urandom)};
  endfunction

  ex_t snap;

  initial begin
    total = 0; bad = 0; m = '0; scnt = 0;
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
    rst = 1'b1; bus.flush = 0; bus.if_valid = 0; bus.if_pc = 0; bus.if_inst = 0;
    bus.fwd_we = 0; bus.fwd_waddr = 0; bus.fwd_wdata = 0; bus.fwd_pend = 0; bus.ex_ready = 1;
    @(negedge clk);
    step(); step();
    chk("rst_valid", bus.ex_valid, 0);
    chk("rst_stall", bus.stall_cnt, 0);
    rst = 1'b0;

    // ori $1,$0,0x1100
    bus.if_valid = 1; bus.if_inst = 32'h34011100; bus.if_pc = 32'h100;
    step();
    chk("ori_valid", bus.ex_valid, 1); chk("ori_op1", bus.ex_op1, 0);
    chk("ori_op2", bus.ex_op2, 32'h1100); chk("ori_wd", bus.ex_wd, 1);
    chk("ori_wreg", bus.ex_wreg, 1); chk("ori_sel", bus.ex_alusel, 3'd1);

    // youngest source wins: or $3,$1,$1
    bus.fwd_we = 2'b11; bus.fwd_waddr = {5'd1, 5'd1}; bus.fwd_wdata = {32'h0000BBBB, 32'h0000AAAA};
    bus.fwd_pend = 0; bus.if_inst = 32'h00211825; bus.if_pc = 32'h104;
    step();
    chk("prio_op1", bus.ex_op1, 32'h0000AAAA); chk("prio_op2", bus.ex_op2, 32'h0000AAAA);

    // $0 never forwards: or $2,$0,$0
    set_fwd0(5'd0, 32'hFFFFFFFF, 1'b0); bus.if_inst = 32'h00001025; bus.if_pc = 32'h108;
    step();
    chk("zero_op1", bus.ex_op1, 0); chk("zero_op2", bus.ex_op2, 0);

    // load-use on $4: and $5,$4,$4
    set_fwd0(5'd4, 32'hDEADBEEF, 1'b1); bus.if_inst = 32'h00842824; bus.if_pc = 32'h10c;
    for (int i = 0; i < 2; i++) begin
      #1 chk("lu_ready", bus.if_ready, 0);
      step();
      chk("lu_bubble", bus.ex_valid, 0);
    end
    chk("lu_stall", bus.stall_cnt, 2);
    set_fwd0(5'd4, 32'h12345678, 1'b0);
    step();
    chk("lu_valid", bus.ex_valid, 1); chk("lu_op1", bus.ex_op1, 32'h12345678);

    // back-pressure then flush
    bus.fwd_we = 0; bus.ex_ready = 0; bus.if_inst = 32'h34021234; bus.if_pc = 32'h110;
    snap = {bus.ex_valid, bus.ex_aluop, bus.ex_alusel, bus.ex_op1, bus.ex_op2,
            bus.ex_wd, bus.ex_wreg, bus.ex_pc, bus.ex_invalid};
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", bus.if_ready, 0);
      step();
      chk("bp_stable_a", {bus.ex_op1, bus.ex_op2}, {snap.op1, snap.op2});
      chk("bp_stable_b", {bus.ex_valid, bus.ex_aluop, bus.ex_alusel, bus.ex_wd, bus.ex_wreg,
                          bus.ex_pc, bus.ex_invalid},
          {snap.vld, snap.op, snap.sel, snap.wd, snap.wreg, snap.pc, snap.inv});
    end
    bus.flush = 1; bus.ex_ready = 1;
    step();
    chk("fl_valid", bus.ex_valid, 0); chk("fl_pc", bus.ex_pc, snap.pc);
    bus.flush = 0;

    // movn $5,$6,$7 and an undecodable word
    bus.if_inst = 32'h00C7280B; bus.if_pc = 32'h200;
    set_fwd0(5'd7, 32'd0, 1'b0); step(); chk("movn0_wreg", bus.ex_wreg, 0);
    set_fwd0(5'd7, 32'd1, 1'b0); step(); chk("movn1_wreg", bus.ex_wreg, 1);
    bus.if_inst = 32'hFC000000; bus.if_pc = 32'h204; step();
    chk("inv_flag", bus.ex_invalid, 1); chk("inv_wreg", bus.ex_wreg, 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      bus.flush   = ($urandom_range(0, 19) == 0);
      bus.if_valid = ($urandom_range(0, 3) != 0);
      bus.ex_ready = ($urandom_range(0, 3) != 0);
      bus.if_inst = rnd_inst();
      bus.if_pc   = $urandom;
      for (int i = 0; i < FWD_N; i++) begin
        bus.fwd_we[i] = 1'($urandom_range(0, 1));
        bus.fwd_waddr[i*REG_AW +: REG_AW] = 5'($urandom_range(0, 7));
        bus.fwd_wdata[i*DATA_W +: DATA_W] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1)) : $urandom;
        bus.fwd_pend[i] = ($urandom_range(0, 5) == 0);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
